// File: rtl/array_40_ctrl.sv
// -----------------------------------------------------------------------------
// array_40_ctrl
// Requester-side controller for a 512x152 single-port masked SRAM
// (8 mask segments of 19 bits, 1-cycle registered read).
// Arbitrates a write-request and a read-request channel onto the single RW0
// port and returns read data in order through a small response FIFO.
//
// Optional feature (macro ARRAY_40_CTRL_INIT_EN): after reset the controller
// sweeps the whole array writing zeros before accepting any requests.
//
// Ports:
//   clock, reset            sole clock (shared with SRAM), sync active-high reset
//   io_wreq_*               write request channel (valid/ready, addr, mask, data)
//   io_rreq_*               read request channel (valid/ready, addr)
//   io_rresp_*              read response channel (valid/ready, data)
//   io_busy                 read in flight, response buffered, or init sweep
//   RW0_*                   SRAM port (addr, en, wmode, wmask, wdata, rdata)
// -----------------------------------------------------------------------------
module array_40_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 152,
    parameter int MASK_W     = 8,
    parameter int RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wreq_valid,
    output logic              io_wreq_ready,
    input  logic [ADDR_W-1:0] io_wreq_addr,
    input  logic [MASK_W-1:0] io_wreq_mask,
    input  logic [DATA_W-1:0] io_wreq_data,
    input  logic              io_rreq_valid,
    output logic              io_rreq_ready,
    input  logic [ADDR_W-1:0] io_rreq_addr,
    output logic              io_rresp_valid,
    input  logic              io_rresp_ready,
    output logic [DATA_W-1:0] io_rresp_data,
    output logic              io_busy,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = $clog2(RESP_DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic              r_inflight;
    logic              r_last_was_write;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [DATA_W-1:0] r_buf [RESP_DEPTH];

    logic              w_run;
    logic              w_init;
    logic [CNT_W:0]    w_outstanding;
    logic              w_rd_elig;
    logic              w_wv;
    logic              w_rv;
    logic              w_grant_w;
    logic              w_grant_r;
    logic              w_push;
    logic              w_pop;

`ifdef ARRAY_40_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_init_addr <= r_init_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_addr == '1) w_state_nxt = ST_RUN;
    end

    assign w_run  = !reset && (r_state == ST_RUN);
    assign w_init = !reset && (r_state == ST_INIT);
    assign io_busy = reset || (r_state == ST_INIT) || r_inflight || (r_count != '0);
`else
    assign w_run   = !reset;
    assign w_init  = 1'b0;
    assign io_busy = !reset && (r_inflight || (r_count != '0));
`endif

    // A read only goes out when its response is guaranteed a buffer slot;
    // the credit uses registered state only, so rresp_ready never reaches rreq_ready.
    assign w_outstanding = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
    assign w_rd_elig     = w_outstanding < (CNT_W + 1)'(RESP_DEPTH);

    assign w_wv = w_run && io_wreq_valid;
    assign w_rv = w_run && io_rreq_valid && w_rd_elig;

    // Contested cycles alternate; uncontested grants leave the history alone.
    assign w_grant_r = w_rv && (!w_wv || r_last_was_write);
    assign w_grant_w = w_wv && !w_grant_r;

    assign io_wreq_ready = w_grant_w;
    assign io_rreq_ready = w_grant_r;

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (w_init) begin
`ifdef ARRAY_40_CTRL_INIT_EN
            RW0_addr = r_init_addr;
`endif
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_wmask = '1;
        end else if (w_grant_w) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = io_wreq_addr;
            RW0_wmask = io_wreq_mask;
            RW0_wdata = io_wreq_data;
        end else if (w_grant_r) begin
            RW0_en   = 1'b1;
            RW0_addr = io_rreq_addr;
        end
    end

    // Response FIFO: SRAM data arrives the cycle after the read grant.
    assign w_push         = r_inflight;
    assign io_rresp_valid = !reset && (r_count != '0);
    assign w_pop          = io_rresp_valid && io_rresp_ready;
    assign io_rresp_data  = r_buf[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight       <= 1'b0;
            r_last_was_write <= 1'b0;
            r_count          <= '0;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
        end else begin
            r_inflight <= w_grant_r;
            if (w_wv && w_rv) r_last_was_write <= w_grant_w;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_buf[r_wr_ptr] <= RW0_rdata;
    end

endmodule

// File: tb/tb_array_40_ctrl.sv
// -----------------------------------------------------------------------------
// tb_array_40_ctrl
// Self-checking bench for array_40_ctrl: a behavioural SRAM drives RW0_rdata,
// and a reference model (memory image + queue of pending responses with their
// earliest visible cycle) predicts grants, RW0 fields and response data.
// -----------------------------------------------------------------------------
module tb_array_40_ctrl;

    localparam int ADDR_W = 9;
    localparam int W      = 152;
    localparam int MASK_W = 8;
    localparam int SEG    = 19;
    localparam int DEPTH  = 3;
    localparam int WORDS  = 512;

    logic              clock;
    logic              reset;
    logic              io_wreq_valid;
    logic              io_wreq_ready;
    logic [ADDR_W-1:0] io_wreq_addr;
    logic [MASK_W-1:0] io_wreq_mask;
    logic [W-1:0]      io_wreq_data;
    logic              io_rreq_valid;
    logic              io_rreq_ready;
    logic [ADDR_W-1:0] io_rreq_addr;
    logic              io_rresp_valid;
    logic              io_rresp_ready;
    logic [W-1:0]      io_rresp_data;
    logic              io_busy;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [MASK_W-1:0] RW0_wmask;
    logic [W-1:0]      RW0_wdata;
    logic [W-1:0]      RW0_rdata;

    array_40_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(W), .MASK_W(MASK_W), .RESP_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .io_wreq_valid(io_wreq_valid), .io_wreq_ready(io_wreq_ready),
        .io_wreq_addr(io_wreq_addr), .io_wreq_mask(io_wreq_mask),
        .io_wreq_data(io_wreq_data),
        .io_rreq_valid(io_rreq_valid), .io_rreq_ready(io_rreq_ready),
        .io_rreq_addr(io_rreq_addr),
        .io_rresp_valid(io_rresp_valid), .io_rresp_ready(io_rresp_ready),
        .io_rresp_data(io_rresp_data), .io_busy(io_busy),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM: masked write, registered read.
    logic [W-1:0] sram [WORDS];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int s = 0; s < MASK_W; s++)
                    if (RW0_wmask[s]) sram[RW0_addr][s*SEG +: SEG] <= RW0_wdata[s*SEG +: SEG];
            end else begin
                RW0_rdata <= sram[RW0_addr];
            end
        end
    end

    typedef struct packed {
        logic [W-1:0] d;
        int unsigned  avail;
    } rsp_t;

    logic [W-1:0] ref_mem [WORDS];
    rsp_t         q[$];
    bit           lw;
    int unsigned  cyc;
    int           n_tests;
    int           n_fail;
    int           init_left;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                           input logic [MASK_W-1:0] m);
        logic [W-1:0] bm;
        bm = '0;
        for (int s = 0; s < MASK_W; s++)
            if (m[s]) bm[s*SEG +: SEG] = {SEG{1'b1}};
        return (old_v & ~bm) | (new_v & bm);
    endfunction

    // One clock cycle: check outputs at the falling edge against the model,
    // advance the model with the handshakes of this cycle, then cross the edge.
    task automatic step();
        bit wv, re, gw, gr, ev;
        @(negedge clock);
        if (reset) begin
            chk("rst_wready", W'(io_wreq_ready), W'(0));
            chk("rst_rready", W'(io_rreq_ready), W'(0));
            chk("rst_rvalid", W'(io_rresp_valid), W'(0));
            chk("rst_en", W'(RW0_en), W'(0));
`ifdef ARRAY_40_CTRL_INIT_EN
            chk("rst_busy", W'(io_busy), W'(1));
            init_left = WORDS;
`else
            chk("rst_busy", W'(io_busy), W'(0));
`endif
            q.delete();
            lw = 1'b0;
        end else if (init_left > 0) begin
            chk("init_wready", W'(io_wreq_ready), W'(0));
            chk("init_rready", W'(io_rreq_ready), W'(0));
            chk("init_busy", W'(io_busy), W'(1));
            chk("init_en", W'(RW0_en), W'(1));
            chk("init_wmode", W'(RW0_wmode), W'(1));
            chk("init_addr", W'(RW0_addr), W'(WORDS - init_left));
            chk("init_mask", W'(RW0_wmask), W'(8'hFF));
            chk("init_wdata", RW0_wdata, W'(0));
            ref_mem[WORDS - init_left] = '0;
            init_left--;
        end else begin
            wv = io_wreq_valid;
            re = io_rreq_valid && (q.size() < DEPTH);
            gr = re && (!wv || lw);
            gw = wv && !gr;
            if (wv && re) lw = gw;
            chk("wready", W'(io_wreq_ready), W'(gw));
            chk("rready", W'(io_rreq_ready), W'(gr));
            chk("en", W'(RW0_en), W'(gw || gr));
            if (gw) begin
                chk("w_wmode", W'(RW0_wmode), W'(1));
                chk("w_addr", W'(RW0_addr), W'(io_wreq_addr));
                chk("w_mask", W'(RW0_wmask), W'(io_wreq_mask));
                chk("w_data", RW0_wdata, io_wreq_data);
            end
            if (gr) begin
                chk("r_wmode", W'(RW0_wmode), W'(0));
                chk("r_addr", W'(RW0_addr), W'(io_rreq_addr));
                chk("r_mask", W'(RW0_wmask), W'(0));
            end
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("rvalid", W'(io_rresp_valid), W'(ev));
            chk("busy", W'(io_busy), W'(q.size() > 0));
            if (ev) begin
                chk("rdata", io_rresp_data, q[0].d);
                if (io_rresp_ready) void'(q.pop_front());
            end
            if (gw) ref_mem[io_wreq_addr] = merge(ref_mem[io_wreq_addr], io_wreq_data, io_wreq_mask);
            if (gr) q.push_back('{d: ref_mem[io_rreq_addr], avail: cyc + 2});
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        io_wreq_valid = 1'b0;
        io_rreq_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        while (init_left > 0) step();
    endtask

    task automatic wr(input int a, input logic [MASK_W-1:0] m, input logic [W-1:0] d);
        io_wreq_valid = 1'b1;
        io_wreq_addr  = ADDR_W'(a);
        io_wreq_mask  = m;
        io_wreq_data  = d;
        step();
        io_wreq_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_data();
        return W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    int acc;
    int pops;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; lw = 1'b0; init_left = 0;
        for (int i = 0; i < WORDS; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        RW0_rdata      = '0;
        io_wreq_addr   = '0; io_wreq_mask = '0; io_wreq_data = '0;
        io_rreq_addr   = '0;
        io_rresp_ready = 1'b1;
        do_reset();

`ifdef ARRAY_40_CTRL_INIT_EN
        // After the sweep, the last address reads back zero.
        io_rreq_valid = 1'b1; io_rreq_addr = 9'd511;
        step();
        io_rreq_valid = 1'b0;
        step();
        step();
        chk("init_rd511_v", W'(io_rresp_valid), W'(1));
        chk("init_rd511_d", io_rresp_data, W'(0));
        step();
`endif

        // Write then read back with exact 2-cycle latency.
        wr(5, 8'hFF, W'(16'h1234));
        io_rreq_valid = 1'b1; io_rreq_addr = 9'd5;
        #1 chk("rd5_fire", W'(io_rreq_ready), W'(1));
        step();
        io_rreq_valid = 1'b0;
        chk("lat_c1_valid", W'(io_rresp_valid), W'(0));
        step();
        chk("lat_c2_valid", W'(io_rresp_valid), W'(1));
        chk("lat_c2_data", io_rresp_data, W'(16'h1234));
        step();

        // Partial mask keeps unmasked segments.
        wr(7, 8'hFF, {W{1'b1}});
        wr(7, 8'h01, W'(0));
        io_rreq_valid = 1'b1; io_rreq_addr = 9'd7;
        step();
        io_rreq_valid = 1'b0;
        step();
        chk("mask_valid", W'(io_rresp_valid), W'(1));
        chk("mask_data", io_rresp_data, {{(W-SEG){1'b1}}, {SEG{1'b0}}});
        step();

        // Contested arbitration alternates W,R,W,R... starting with W.
        do_reset();
        io_rresp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            io_wreq_valid = 1'b1; io_wreq_addr = ADDR_W'($urandom_range(0, 15));
            io_wreq_mask  = 8'($urandom); io_wreq_data = rand_data();
            io_rreq_valid = 1'b1; io_rreq_addr = ADDR_W'($urandom_range(0, 15));
            #1;
            chk("alt_wready", W'(io_wreq_ready), W'(i % 2 == 0));
            chk("alt_en", W'(RW0_en), W'(1));
            step();
        end
        idle_inputs();
        repeat (3) step();

        // Backpressure: exactly three reads accepted, then in-order drain.
        wr(20, 8'hFF, rand_data());
        wr(21, 8'hFF, rand_data());
        wr(22, 8'hFF, rand_data());
        io_rresp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            io_rreq_valid = 1'b1; io_rreq_addr = ADDR_W'(20 + (acc % 3));
            #1 if (io_rreq_ready) acc++;
            step();
        end
        chk("bp_accepted", W'(acc), W'(3));
        chk("bp_rready_low", W'(io_rreq_ready), W'(0));
        io_rreq_valid  = 1'b0;
        io_rresp_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            #1 if (io_rresp_valid) pops++;
            step();
        end
        chk("bp_drained", W'(pops), W'(3));

        // Reset one cycle after a read fires discards it.
        io_rreq_valid = 1'b1; io_rreq_addr = 9'd5;
        step();
        io_rreq_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
`ifdef ARRAY_40_CTRL_INIT_EN
        chk("post_rst_busy", W'(io_busy), W'(1));
`else
        chk("post_rst_busy", W'(io_busy), W'(0));
`endif
        chk("post_rst_valid", W'(io_rresp_valid), W'(0));
        while (init_left > 0) step();
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_noresp", W'(io_rresp_valid), W'(0));
            step();
        end

        // Randomised traffic over a small address window.
        for (int i = 0; i < 3000; i++) begin
            io_wreq_valid  = ($urandom_range(0, 9) < 6);
            io_wreq_addr   = ADDR_W'($urandom_range(0, 15));
            io_wreq_mask   = 8'($urandom);
            io_wreq_data   = rand_data();
            io_rreq_valid  = ($urandom_range(0, 9) < 6);
            io_rreq_addr   = ADDR_W'($urandom_range(0, 15));
            io_rresp_ready = ($urandom_range(0, 9) < 7);
            reset          = ($urandom_range(0, 499) == 0);
            step();
            reset = 1'b0;
            while (init_left > 0) step();
        end
        idle_inputs();
        io_rresp_ready = 1'b1;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/array_40_ctrl.md
Name: array_40_ctrl

Overview:
- Requester-side controller that drives the 512x152 single-port masked SRAM macro (8 mask segments of 19 bits, 1-cycle registered read).
- Accepts independent write-request and read-request channels (valid/ready) from the cache datapath.
- Arbitrates both channels onto the single RW0 port and returns read data through a backpressurable response channel.
- Sits between the datapath and the SRAM; the SRAM shares `clock`.

Parameters:
- ADDR_W, 9, SRAM address width (depth 512)
- DATA_W, 152, SRAM data width
- MASK_W, 8, write-mask segments, each DATA_W/MASK_W = 19 bits
- RESP_DEPTH, 3, read-response buffer entries; minimum 3

Ports:
- clock  input  1  sole clock; also clocks the SRAM
- reset  input  1  synchronous, active-high reset
- io_wreq_valid  input  1  write request valid
- io_wreq_ready  output  1  write request accepted this cycle
- io_wreq_addr  input  ADDR_W  write address
- io_wreq_mask  input  MASK_W  per-segment write enable
- io_wreq_data  input  DATA_W  write data
- io_rreq_valid  input  1  read request valid
- io_rreq_ready  output  1  read request accepted this cycle
- io_rreq_addr  input  ADDR_W  read address
- io_rresp_valid  output  1  read data available
- io_rresp_ready  input  1  consumer takes read data
- io_rresp_data  output  DATA_W  read data, head of response buffer
- io_busy  output  1  in-flight read, buffered response, or init in progress
- RW0_addr  output  ADDR_W  SRAM address
- RW0_en  output  1  SRAM enable
- RW0_wmode  output  1  1 = write, 0 = read
- RW0_wmask  output  MASK_W  SRAM segment mask
- RW0_wdata  output  DATA_W  SRAM write data
- RW0_rdata  input  DATA_W  SRAM read data, valid the cycle after a read-enable edge

Behaviour:
- Reset: the clock and reset are `clock` and `reset`; reset is synchronous and active-high.
  - Reset clears the response buffer, the in-flight flag and last_was_write (to 0).
  - While reset is high: io_wreq_ready=0, io_rreq_ready=0, io_rresp_valid=0, RW0_en=0, io_busy=0 (io_busy=1 when the optional feature is compiled in).
- States: INIT (only with optional feature) and RUN. Without the feature, the first cycle after reset is RUN.
- SRAM port: at most one access per cycle.
  - RW0_* are combinational from the grant; the SRAM samples them at the same edge as the request handshake.
  - Write grant: RW0_en=1, RW0_wmode=1, RW0_addr=io_wreq_addr, RW0_wmask=io_wreq_mask, RW0_wdata=io_wreq_data.
  - Read grant: RW0_en=1, RW0_wmode=0, RW0_wmask=0, RW0_addr=io_rreq_addr.
  - No grant: RW0_en=0.
- Read credit: read is eligible only when (buffer count + in-flight) < RESP_DEPTH. No combinational path from io_rresp_ready to io_rreq_ready.
- Arbitration:
  - Write-only valid: grant write.
  - Eligible-read-only valid: grant read.
  - Both valid and read eligible: grant read if last_was_write=1, else write.
  - last_was_write updates only on contested grants.
- Read latency: rreq fires at edge E → in-flight set → RW0_rdata captured into the buffer at E+1 → io_rresp_valid high in the cycle after E+1 (2 cycles request-to-response).
  - Sustained throughput is 1 read/cycle when io_rresp_ready is held high.
- Response buffer: FIFO with in-order data.
  - Push and pop in the same cycle is allowed.
  - Capture never overflows, because of the credit rule.
- Ordering: a read granted in any cycle after a write grant to the same address returns the newly written segments; unmasked segments keep their old value.
- Reset mid-operation: in-flight read and buffered responses are discarded with no response produced; arbitration restarts with write priority.

Optional Feature:
- Macro: ARRAY_40_CTRL_INIT_EN.
- When defined: after reset deasserts, FSM enters INIT and writes 0 with mask all-ones to addresses 0..511, one per cycle (512 cycles, RW0_en=1, RW0_wmode=1).
  - Both request readies are 0 and io_busy=1 during INIT.
  - Enters RUN after address 511 is written.
  - Reset during INIT restarts the sweep at address 0.
- When undefined: no INIT state; SRAM contents are undefined until written.

Test Plan:
- Write addr 5, mask 0xFF, data 0x1234 (zero-extended), then read addr 5 → io_rresp_valid 2 cycles after read fire, data 0x1234.
- Write addr 7 full with all-ones, then write mask 0x01 with data 0 → read 7 returns all-ones except bits [18:0]=0.
- Wreq and rreq valid every cycle → grants alternate W,R,W,R… starting with W after reset; RW0_en=1 every cycle.
- Hold io_rresp_ready=0 and issue reads back-to-back → exactly 3 accepted, io_rreq_ready=0 afterwards; release ready → data returns in issue order with no loss.
- Assert reset one cycle after a read fires → no io_rresp_valid afterwards; io_busy=0 in the first cycle after reset.
- With ARRAY_40_CTRL_INIT_EN: readies stay 0 for 512 cycles after reset; then a read of addr 511 returns 0.
